// File: rtl/usart_pkg.sv
`default_nettype none
// usart_pkg : shared USART transmitter/receiver state encodings and format codes (rev 1.0)
package usart_pkg;

   localparam int MAX_DATA_WIDTH = 9;

   localparam logic [2:0] TX_IDLE        = 3'd0;
   localparam logic [2:0] TX_START_BIT   = 3'd1;
   localparam logic [2:0] TX_DATA_SEND   = 3'd2;
   localparam logic [2:0] TX_PARITY_SEND = 3'd3;
   localparam logic [2:0] TX_STOP_BIT1   = 3'd4;
   localparam logic [2:0] TX_STOP_BIT2   = 3'd5;

   localparam logic [2:0] UCSZ_5 = 3'd0;
   localparam logic [2:0] UCSZ_6 = 3'd1;
   localparam logic [2:0] UCSZ_7 = 3'd2;
   localparam logic [2:0] UCSZ_8 = 3'd3;
   localparam logic [2:0] UCSZ_9 = 3'd7;

   localparam logic [1:0] UPM_EVEN = 2'b10;
   localparam logic [1:0] UPM_ODD  = 2'b11;

   // Reserved size codes 4-6 fall back to 8 bits.
   function automatic logic [3:0] char_bits(input logic [2:0] ucsz);
      case (ucsz)
         UCSZ_5:  char_bits = 4'd5;
         UCSZ_6:  char_bits = 4'd6;
         UCSZ_7:  char_bits = 4'd7;
         UCSZ_8:  char_bits = 4'd8;
         UCSZ_9:  char_bits = 4'd9;
         default: char_bits = 4'd8;
      endcase
   endfunction

   function automatic logic [MAX_DATA_WIDTH-1:0] char_mask(input logic [2:0] ucsz);
      char_mask = {MAX_DATA_WIDTH{1'b1}} >> (MAX_DATA_WIDTH - int'(char_bits(ucsz)));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_tx1.sv
`default_nettype none
// fsm_tx1 : channel-1 transmit frame sequencer with load/shift/count enables (rev 1.0)
module fsm_tx1
   import usart_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_bit_tick,
   input  logic       i_buf_full,
   input  logic       i_cnt_zero,
   input  logic       i_par_en,
   input  logic       i_two_stop,
   output logic [2:0] o_next_state,
   output logic       o_load,
   output logic       o_shift_en,
   output logic       o_cnt_dec,
   output logic       o_complete,
   output logic       o_busy
);

   logic [2:0] r_state;
   logic [2:0] w_next;
   logic       w_frame_end;

   always_comb begin
      w_frame_end = 1'b0;
      w_next      = r_state;
      case (r_state)
         TX_IDLE:        if (i_buf_full) w_next = TX_START_BIT;
         TX_START_BIT:   w_next = TX_DATA_SEND;
         TX_DATA_SEND:   if (i_cnt_zero) w_next = i_par_en ? TX_PARITY_SEND : TX_STOP_BIT1;
         TX_PARITY_SEND: w_next = TX_STOP_BIT1;
         TX_STOP_BIT1:   if (i_two_stop) w_next = TX_STOP_BIT2;
                         else            w_frame_end = 1'b1;
         TX_STOP_BIT2:   w_frame_end = 1'b1;
         default:        w_next = TX_IDLE;
      endcase
      // A pending character chains straight into the next start bit.
      if (w_frame_end) w_next = i_buf_full ? TX_START_BIT : TX_IDLE;
      if (!i_bit_tick) w_next = r_state;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= TX_IDLE;
      else          r_state <= w_next;
   end

   assign o_next_state = w_next;
   assign o_load       = i_bit_tick & i_buf_full & ((r_state == TX_IDLE) | w_frame_end);
   assign o_complete   = i_bit_tick & w_frame_end & ~i_buf_full;
   assign o_shift_en   = i_bit_tick & (w_next == TX_DATA_SEND);
   assign o_cnt_dec    = i_bit_tick & (r_state == TX_DATA_SEND) & ~i_cnt_zero;
   assign o_busy       = (r_state != TX_IDLE);

endmodule
`default_nettype wire

// File: rtl/usart_tx1.sv
`default_nettype none
// usart_tx1 : USART channel-1 transmitter - holding buffer, shifter and line driver (rev 1.0)
module usart_tx1
   import usart_pkg::*;
(
   input  logic                      i_txclk,
   input  logic                      i_rst_n,
   input  logic                      i_bit_tick,
   input  logic                      i_txen,
   input  logic [MAX_DATA_WIDTH-1:0] i_data,
   input  logic                      i_data_valid,
   output logic                      o_data_ready,
   input  logic [2:0]                i_ucsz,
   input  logic [1:0]                i_upm,
   input  logic                      i_usbs,
   output logic                      o_txd,
   output logic                      o_tx_busy,
   output logic                      o_tx_complete
);

   logic [MAX_DATA_WIDTH-1:0] r_buf;
   logic [MAX_DATA_WIDTH-1:0] r_shift;
   logic                      r_buf_full;
   logic [3:0]                r_cnt;
   logic                      r_parity;
   logic                      r_par_en;
   logic                      r_two_stop;
   logic                      r_txd;
   logic                      r_tx_complete;

   logic [MAX_DATA_WIDTH-1:0] w_mask;
   logic [2:0]                w_next_state;
   logic                      w_write;
   logic                      w_load;
   logic                      w_shift_en;
   logic                      w_cnt_dec;
   logic                      w_complete;
   logic                      w_busy;
   logic                      w_par_bit;
   logic                      w_par_en;
   logic                      w_txd_next;

   assign o_data_ready = ~r_buf_full & i_txen;
   assign w_write      = i_data_valid & o_data_ready;
   assign w_mask       = char_mask(i_ucsz);
   assign w_par_en     = (i_upm == UPM_EVEN) | (i_upm == UPM_ODD);
   assign w_par_bit    = (^(r_buf & w_mask)) ^ (i_upm == UPM_ODD);

   fsm_tx1 u_fsm (
      .i_clk        (i_txclk),
      .i_rst_n      (i_rst_n),
      .i_bit_tick   (i_bit_tick),
      .i_buf_full   (r_buf_full),
      .i_cnt_zero   (r_cnt == 4'd0),
      .i_par_en     (r_par_en),
      .i_two_stop   (r_two_stop),
      .o_next_state (w_next_state),
      .o_load       (w_load),
      .o_shift_en   (w_shift_en),
      .o_cnt_dec    (w_cnt_dec),
      .o_complete   (w_complete),
      .o_busy       (w_busy)
   );

   // Write and load can never coincide: a write needs an empty buffer, a load a full one.
   always_ff @(posedge i_txclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buf      <= '0;
         r_buf_full <= 1'b0;
      end else if (w_write) begin
         r_buf      <= i_data;
         r_buf_full <= 1'b1;
      end else if (w_load) begin
         r_buf_full <= 1'b0;
      end
   end

   always_ff @(posedge i_txclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift    <= '0;
         r_cnt      <= 4'd0;
         r_parity   <= 1'b0;
         r_par_en   <= 1'b0;
         r_two_stop <= 1'b0;
      end else if (w_load) begin
         r_shift    <= r_buf & w_mask;
         r_cnt      <= char_bits(i_ucsz) - 4'd1;
         r_parity   <= w_par_bit;
         r_par_en   <= w_par_en;
         r_two_stop <= i_usbs;
      end else begin
         if (w_shift_en) r_shift <= {1'b0, r_shift[MAX_DATA_WIDTH-1:1]};
         if (w_cnt_dec)  r_cnt   <= r_cnt - 4'd1;
      end
   end

   always_comb begin
      w_txd_next = 1'b1;
      case (w_next_state)
         TX_START_BIT:   w_txd_next = 1'b0;
         TX_DATA_SEND:   w_txd_next = r_shift[0];
         TX_PARITY_SEND: w_txd_next = r_parity;
         default:        w_txd_next = 1'b1;
      endcase
   end

   always_ff @(posedge i_txclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_txd         <= 1'b1;
         r_tx_complete <= 1'b0;
      end else if (i_bit_tick) begin
         r_txd         <= w_txd_next;
         r_tx_complete <= w_complete;
      end else begin
         r_tx_complete <= 1'b0;
      end
   end

   assign o_txd         = r_txd;
   assign o_tx_busy     = w_busy;
   assign o_tx_complete = r_tx_complete;

endmodule
`default_nettype wire
